multi_engine_station: RTL

Parametrised station node that attaches NUM_ENGINES matching engines to one thread ring, replacing the single-engine station-plus-channel pairing. Incoming ring threads are delivered round-robin to any accepting local engine or forwarded downstream. Engine-spawned threads are merged with forwarded threads into one output FIFO. The FIFO also tracks, per character-context id, which ids are still in flight.

---
 rtl/station_pkg.sv | 39 +++
 rtl/station_fifo.sv | 65 ++++++
 rtl/multi_engine_station.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/station_pkg.sv
// Shared types and helpers for the multi-engine station: thread word layout
// and the circular first-set search used by both round-robin arbiters.
package station_pkg;

    localparam int PC_WIDTH_DEF   = 8;
    localparam int CC_ID_BITS_DEF = 2;
    localparam int MAX_PORTS      = 16;

    function automatic int thread_w(input int pc_w, input int id_w);
        return pc_w + id_w;
    endfunction

    typedef struct packed {
        logic [PC_WIDTH_DEF-1:0]   pc;
        logic [CC_ID_BITS_DEF-1:0] cc_id;
    } thread_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // Scan downwards so the candidate closest to ptr is the one left standing.
    function automatic pick_t first_set(input logic [MAX_PORTS-1:0] req,
                                        input logic [3:0] ptr, input int n);
        pick_t p;
        int    idx;
        p = '0;
        for (int k = MAX_PORTS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && req[idx]) begin
                p.found = 1'b1;
                p.idx   = 4'(idx);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/station_fifo.sv
// Synchronous output FIFO with occupancy count and per-character-context
// counters telling which cc ids still have threads queued.
module station_fifo
    import station_pkg::*;
#(
    parameter int DW         = 10,
    parameter int ID_BITS    = 2,
    parameter int DEPTH_BITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DW-1:0]         wr_data,
    input  logic                  rd_en,
    output logic [DW-1:0]         rd_data,
    output logic [DEPTH_BITS:0]   count,
    output logic [2**ID_BITS-1:0] id_busy
);
    localparam int NID = 2**ID_BITS;
    localparam logic [DEPTH_BITS:0]   CNT_ONE = 1;
    localparam logic [DEPTH_BITS-1:0] PTR_ONE = 1;

    logic [DW-1:0]         mem_q [2**DEPTH_BITS];
    logic [DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic [DEPTH_BITS:0]   cnt_q [NID];
    logic [DEPTH_BITS:0]   cnt_d [NID];

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        for (int k = 0; k < NID; k++) begin
            cnt_d[k] = cnt_q[k];
            if (wr_en && wr_data[ID_BITS-1:0] == ID_BITS'(k)) cnt_d[k] = cnt_d[k] + CNT_ONE;
            if (rd_en && rd_data[ID_BITS-1:0] == ID_BITS'(k)) cnt_d[k] = cnt_d[k] - CNT_ONE;
            id_busy[k] = (cnt_q[k] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int k = 0; k < NID; k++) cnt_q[k] <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
            for (int k = 0; k < NID; k++) cnt_q[k] <= cnt_d[k];
        end
    end

endmodule

// File: rtl/multi_engine_station.sv
// Ring station serving NUM_ENGINES engines: delivers or forwards ring threads
// and merges engine output into one FIFO. Optional STATION_STARVATION_GUARD_EN.
module multi_engine_station
    import station_pkg::*;
#(
    parameter int  PC_WIDTH        = 8,
    parameter int  CC_ID_BITS      = 2,
    parameter int  NUM_ENGINES     = 4,
    parameter int  FIFO_DEPTH_BITS = 3,
    parameter int  MAX_WAIT        = 8,
    localparam int DW              = thread_w(PC_WIDTH, CC_ID_BITS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ring_in_valid,
    output logic                      ring_in_ready,
    input  logic [DW-1:0]             ring_in_data,
    input  logic [NUM_ENGINES-1:0]    eng_accepts,
    output logic [NUM_ENGINES-1:0]    to_eng_valid,
    input  logic [NUM_ENGINES-1:0]    to_eng_ready,
    output logic [DW-1:0]             to_eng_data,
    input  logic [NUM_ENGINES-1:0]    from_eng_valid,
    output logic [NUM_ENGINES-1:0]    from_eng_ready,
    input  logic [NUM_ENGINES*DW-1:0] from_eng_data,
    output logic                      ring_out_valid,
    input  logic                      ring_out_ready,
    output logic [DW-1:0]             ring_out_data,
    output logic [2**CC_ID_BITS-1:0]  elaborating_chars,
    output logic                      station_full,
    output logic                      station_running
);
    localparam logic [FIFO_DEPTH_BITS:0] DEPTH_C = (FIFO_DEPTH_BITS+1)'(2**FIFO_DEPTH_BITS);
    localparam logic [3:0] LAST = 4'(NUM_ENGINES - 1);

    logic                       slot_v_q, slot_v_d;
    logic [DW-1:0]              slot_q, slot_d;
    logic [3:0]                 dlv_ptr_q, dlv_ptr_d, inj_ptr_q, inj_ptr_d;
    logic [MAX_PORTS-1:0]       acc_pad, fev_pad, rdy_pad;
    pick_t                      dlv, inj;
    logic [FIFO_DEPTH_BITS:0]   count;
    logic [2**CC_ID_BITS-1:0]   id_busy;
    logic                       fwd_req, fwd_wr, eng_wr, deliver, slot_leaves, space, eng_first, rd_en;
    logic [DW-1:0]              eng_word, wr_data;

    always_comb begin
        acc_pad = '0;
        fev_pad = '0;
        rdy_pad = '0;
        acc_pad[NUM_ENGINES-1:0] = eng_accepts;
        fev_pad[NUM_ENGINES-1:0] = from_eng_valid;
        rdy_pad[NUM_ENGINES-1:0] = to_eng_ready;
        dlv = first_set(acc_pad, dlv_ptr_q, NUM_ENGINES);
        inj = first_set(fev_pad, inj_ptr_q, NUM_ENGINES);
    end

    // Forwarding keeps the ring moving, so it outranks engine output unless
    // the starvation guard has fired.
    assign space       = (count < DEPTH_C);
    assign fwd_req     = slot_v_q & ~dlv.found;
    assign fwd_wr      = space & fwd_req & ~(eng_first & inj.found);
    assign eng_wr      = space & inj.found & ~fwd_wr;
    assign deliver     = slot_v_q & dlv.found & rdy_pad[dlv.idx];
    assign slot_leaves = deliver | fwd_wr;
    assign wr_data     = fwd_wr ? slot_q : eng_word;
    assign rd_en       = ring_out_valid & ring_out_ready;

    always_comb begin
        eng_word = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            to_eng_valid[i]   = slot_v_q & dlv.found & (dlv.idx == 4'(i));
            from_eng_ready[i] = eng_wr & (inj.idx == 4'(i));
            if (inj.idx == 4'(i)) eng_word = from_eng_data[i*DW +: DW];
        end
    end

    assign ring_in_ready   = ~slot_v_q | slot_leaves;
    assign to_eng_data     = slot_q;
    assign ring_out_valid  = (count != '0);
    assign station_full    = (count == DEPTH_C) & slot_v_q;
    assign station_running = ring_out_valid | slot_v_q;

    always_comb begin
        for (int k = 0; k < 2**CC_ID_BITS; k++)
            elaborating_chars[k] = id_busy[k] | (slot_v_q & (slot_q[CC_ID_BITS-1:0] == CC_ID_BITS'(k)));
    end

    always_comb begin
        slot_v_d  = slot_v_q;
        slot_d    = slot_q;
        dlv_ptr_d = dlv_ptr_q;
        inj_ptr_d = inj_ptr_q;
        if (slot_leaves) slot_v_d = 1'b0;
        if (ring_in_valid && ring_in_ready) begin
            slot_v_d = 1'b1;
            slot_d   = ring_in_data;
        end
        if (deliver) dlv_ptr_d = (dlv.idx == LAST) ? 4'd0 : dlv.idx + 4'd1;
        if (eng_wr)  inj_ptr_d = (inj.idx == LAST) ? 4'd0 : inj.idx + 4'd1;
    end

    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_v_q  <= 1'b0;
            dlv_ptr_q <= '0;
            inj_ptr_q <= '0;
        end else begin
            slot_v_q  <= slot_v_d;
            dlv_ptr_q <= dlv_ptr_d;
            inj_ptr_q <= inj_ptr_d;
        end
    end

`ifdef STATION_STARVATION_GUARD_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0] wait_q;

    assign eng_first = (wait_q == WW'(MAX_WAIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q <= '0;
        end else if (eng_wr) begin
            wait_q <= '0;
        end else if (fwd_wr && (|from_eng_valid) && !eng_first) begin
            wait_q <= wait_q + WW'(1);
        end
    end
`else
    localparam int unused_max_wait = MAX_WAIT;
    assign eng_first = 1'b0;
`endif

    station_fifo #(
        .DW         (DW),
        .ID_BITS    (CC_ID_BITS),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .wr_en   (fwd_wr | eng_wr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (ring_out_data),
        .count   (count),
        .id_busy (id_busy)
    );

endmodule
